// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator between the CPU execute stage and a
// 256 x 16-bit data memory. It accepts one request at a time and returns one
// response per request. Byte stores run as a read-modify-write sequence.
// Optional build macro LSU_PERF_CNT_EN adds perf_loads / perf_stores counters.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [15:0]       perf_loads,
  output logic [15:0]       perf_stores
`endif
);

  localparam int BYTE_W = DATA_W / 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_RMW_RD = 3'd3;
  localparam logic [2:0] S_RMW_WR = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  logic [2:0]        state_q,      state_d;
  logic              req_ready_q,  req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q,   resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              mem_we_q,     mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
  logic              lane_hi_q,    lane_hi_d;
  logic              byte_q,       byte_d;
  logic              sign_q,       sign_d;
  logic [BYTE_W-1:0] wbyte_q,      wbyte_d;

  // Pick one byte lane out of a word and zero- or sign-extend it.
  function automatic logic [DATA_W-1:0] lane_extract(input logic [DATA_W-1:0] word,
                                                     input logic hi, input logic sgn);
    logic [BYTE_W-1:0] b;
    if (hi) begin
      b = word[DATA_W-1:BYTE_W];
    end else begin
      b = word[BYTE_W-1:0];
    end
    return {{(DATA_W-BYTE_W){sgn & b[BYTE_W-1]}}, b};
  endfunction

  // Replace one byte lane of a word, keeping the other lane intact.
  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] word,
                                                   input logic hi, input logic [BYTE_W-1:0] b);
    if (hi) begin
      return {b, word[BYTE_W-1:0]};
    end else begin
      return {word[DATA_W-1:BYTE_W], b};
    end
  endfunction

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    lane_hi_d    = lane_hi_q;
    byte_d       = byte_q;
    sign_d       = sign_q;
    wbyte_d      = wbyte_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_ready_d = 1'b0;
          mem_addr_d  = {1'b0, req_addr[ADDR_W-1:1]};
          lane_hi_d   = req_addr[0];
          byte_d      = req_byte;
          sign_d      = req_sign;
          wbyte_d     = req_wdata[BYTE_W-1:0];
          if (!req_byte && req_addr[0]) begin
            // Misaligned word access: answer immediately, never touch memory.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = {DATA_W{1'b0}};
          end else if (!req_we) begin
            state_d = S_READ;
          end else if (!req_byte) begin
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = S_RMW_RD;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      S_READ: begin
        if (byte_q) begin
          resp_rdata_d = lane_extract(mem_rdata, lane_hi_q, sign_q);
        end else begin
          resp_rdata_d = mem_rdata;
        end
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        state_d      = S_RESP;
      end
      S_WRITE: begin
        mem_we_d     = 1'b0;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = {DATA_W{1'b0}};
        state_d      = S_RESP;
      end
      S_RMW_RD: begin
        mem_wdata_d = lane_merge(mem_rdata, lane_hi_q, wbyte_q);
        mem_we_d    = 1'b1;
        state_d     = S_RMW_WR;
      end
      S_RMW_WR: begin
        mem_we_d     = 1'b0;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = {DATA_W{1'b0}};
        state_d      = S_RESP;
      end
      S_RESP: begin
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = {DATA_W{1'b0}};
        req_ready_d  = 1'b1;
        state_d      = S_IDLE;
      end
      default: begin
        state_d      = S_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        mem_we_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= {DATA_W{1'b0}};
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      lane_hi_q    <= 1'b0;
      byte_q       <= 1'b0;
      sign_q       <= 1'b0;
      wbyte_q      <= {BYTE_W{1'b0}};
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      lane_hi_q    <= lane_hi_d;
      byte_q       <= byte_d;
      sign_q       <= sign_d;
      wbyte_q      <= wbyte_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

`ifdef LSU_PERF_CNT_EN
  logic        we_q;
  logic [15:0] perf_loads_q;
  logic [15:0] perf_stores_q;

  // Remember the access direction so the response can be classified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
    end else if (state_q == S_IDLE && req_valid) begin
      we_q <= req_we;
    end else begin
      we_q <= we_q;
    end
  end

  // Count successful responses; wrap naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loads_q  <= 16'd0;
      perf_stores_q <= 16'd0;
    end else if (state_q == S_RESP && !resp_err_q) begin
      if (we_q) begin
        perf_stores_q <= perf_stores_q + 16'd1;
      end else begin
        perf_loads_q <= perf_loads_q + 16'd1;
      end
    end else begin
      perf_loads_q  <= perf_loads_q;
      perf_stores_q <= perf_stores_q;
    end
  end

  assign perf_loads  = perf_loads_q;
  assign perf_stores = perf_stores_q;
`endif

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store initiator that sits between the CPU execute stage and the 256 x 16-bit data memory. It accepts one byte-addressed load or store request at a time over a valid/ready handshake and drives the memory's write-enable, address and write-data pins. It samples the memory's combinational read data and returns one response per request. Byte stores use a read-modify-write sequence, because the memory only supports whole-word writes.

Parameters:
ADDR_W, 16, CPU-side byte address width
DATA_W, 16, data word width; fixed at 16, byte lanes derived from it

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  CPU request present
req_ready  output  1  controller can accept request (IDLE only)
req_we  input  1  1 = store, 0 = load
req_byte  input  1  1 = byte access, 0 = word access
req_sign  input  1  byte load: 1 = sign-extend, 0 = zero-extend
req_addr  input  16  CPU byte address
req_wdata  input  16  store data (byte store uses [7:0])
resp_valid  output  1  one-cycle response pulse
resp_err  output  1  valid with resp_valid; misaligned word access
resp_rdata  output  16  load result, valid with resp_valid
mem_we  output  1  memory write enable
mem_addr  output  16  memory word address = {1'b0, captured_addr[15:1]}
mem_wdata  output  16  memory write data
mem_rdata  input  16  memory combinational read data

Behaviour:
- Reset: all outputs are driven from registers.
  - State = IDLE; req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
- Addressing:
  - Word index = req_addr[8:1]; the memory uses the low 8 bits of mem_addr.
  - Byte lane: addr[0]=0 → bits [7:0]; addr[0]=1 → bits [15:8] (little-endian).
  - Word access with addr[0]=1 is misaligned.
- FSM states: IDLE, READ, WRITE, RMW_RD, RMW_WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture addr, wdata, we, byte and sign; req_ready drops the next cycle.
  - Next state:
    - misaligned word access → RESP with err=1
    - load → READ
    - word store → WRITE
    - byte store → RMW_RD
- READ:
  - mem_addr is stable; sample mem_rdata at the end of the cycle.
  - Word load: rdata = mem_rdata.
  - Byte load: selected lane, zero- or sign-extended to 16 bits.
  - Next state → RESP.
- WRITE: mem_we=1 for exactly one cycle with mem_wdata = captured wdata; next state → RESP.
- RMW_RD:
  - Sample mem_rdata.
  - Build the merged word: selected lane replaced by wdata[7:0], the other lane preserved.
  - Next state → RMW_WR.
- RMW_WR: mem_we=1 for one cycle with the merged word; next state → RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; stores also get a response (an ack).
  - resp_rdata = 0 for stores and errors.
  - Next state → IDLE.
- Latency, with the request accepted at edge N:
  - load / word store: resp_valid high in cycle N+2
  - byte store: N+3
  - misaligned: N+1
  - Back-to-back throughput: one request per 3 cycles (4 for byte store).
- mem_we is never asserted outside WRITE/RMW_WR, and never on a misaligned request.
- req_valid held high while not ready has no effect; no request is queued.
- Reset asserted mid-operation:
  - State returns to IDLE immediately (asynchronously); mem_we drops immediately.
  - A pending write is aborted and no response is issued.
  - An RMW aborted after RMW_RD leaves memory unmodified.
- Address bits [15:9] are ignored for memory access (aliasing); they are not an error.

Optional Feature:
LSU_PERF_CNT_EN
- Defined:
  - Adds outputs perf_loads[15:0] and perf_stores[15:0].
  - Each increments by 1 on every RESP for a successful load or store respectively; errors are not counted.
  - Counters wrap 0xFFFF → 0x0000 and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Word store 0xBEEF to addr 0x0010, then word load 0x0010 → mem_we pulses one cycle with mem_addr=0x0008; load returns 0xBEEF with resp_valid in cycle N+2; resp_err=0.
- Word 0x1234 at addr 0x0020; byte store 0xAB to addr 0x0021 → memory word becomes 0xAB34; resp_valid at N+3; exactly one mem_we cycle.
- Word 0x80F0 at addr 0x0030:
  - signed byte load 0x0031 → 0xFF80
  - unsigned byte load 0x0030 → 0x00F0
  - signed byte load 0x0030 → 0xFFF0
- Word load to addr 0x0011 → resp_valid at N+1, resp_err=1, resp_rdata=0, mem_we never asserted; same request with req_we=1 leaves memory unchanged.
- Byte store issued, rst_n pulled low during RMW_RD → mem_we stays 0, no resp_valid; after reset req_ready=1 and the target word is unchanged.
- With LSU_PERF_CNT_EN: 3 loads, 2 stores and 1 misaligned access → perf_loads=3, perf_stores=2; preload perf_stores=0xFFFF, one store → 0x0000.
